rf_access_ctrl: RTL and testbench

RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_wq.sv | 90 +++++++++
 rtl/rf_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file access controller:
// default widths, queue depth and the controller state encoding.
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;
  localparam int WQ_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } rf_state_e;

endpackage

// File: rtl/rf_wq.sv
// Write-back queue: ordered FIFO (entry 0 is the head) with a per-port
// lookup that returns the youngest queued value for a given address.
module rf_wq
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = WQ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] lk_addr_a,
  input  logic [ADDR_W-1:0] lk_addr_b,
  output logic              lk_hit_a,
  output logic              lk_hit_b,
  output logic [DATA_W-1:0] lk_data_a,
  output logic [DATA_W-1:0] lk_data_b
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_pop_s;
  logic              do_pop_s;
  logic              do_push_s;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == {CNT_W{1'b0}});
  assign head_addr = addr_q[0];
  assign head_data = data_q[0];

  // Next queue contents: shift out the head on pop, then append behind the survivors.
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    do_pop_s  = pop && !empty;
    cnt_pop_s = do_pop_s ? (cnt_q - CNT_W'(1)) : cnt_q;
    do_push_s = push && (cnt_pop_s < CNT_W'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) begin
      addr_d[i] = do_pop_s ? addr_q[i+1] : addr_q[i];
      data_d[i] = do_pop_s ? data_q[i+1] : data_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = (do_push_s && (CNT_W'(i) == cnt_pop_s)) ? push_addr : addr_d[i];
      data_d[i] = (do_push_s && (CNT_W'(i) == cnt_pop_s)) ? push_data : data_d[i];
    end
    cnt_d = do_push_s ? (cnt_pop_s + CNT_W'(1)) : cnt_pop_s;
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      addr_q <= '{default: {ADDR_W{1'b0}}};
      data_q <= '{default: {DATA_W{1'b0}}};
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Forwarding lookup: scanning head to tail lets the youngest match win.
  always_comb begin
    lk_hit_a  = 1'b0;
    lk_hit_b  = 1'b0;
    lk_data_a = {DATA_W{1'b0}};
    lk_data_b = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lk_data_a = ((CNT_W'(i) < cnt_q) && (addr_q[i] == lk_addr_a)) ? data_q[i] : lk_data_a;
      lk_hit_a  = lk_hit_a | ((CNT_W'(i) < cnt_q) && (addr_q[i] == lk_addr_a));
      lk_data_b = ((CNT_W'(i) < cnt_q) && (addr_q[i] == lk_addr_b)) ? data_q[i] : lk_data_b;
      lk_hit_b  = lk_hit_b | ((CNT_W'(i) < cnt_q) && (addr_q[i] == lk_addr_b));
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file access controller: arbitrates queued write-backs against
// two-operand reads over a single-ported register-file interface.
module rf_access_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_adr_save,
  output logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_adr_a,
  output logic [ADDR_W-1:0] rf_adr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b
);

  rf_state_e         state_q, state_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_adr_save_q, rf_adr_save_d;
  logic [DATA_W-1:0] rf_data_out_q, rf_data_out_d;
  logic [ADDR_W-1:0] rf_adr_a_q, rf_adr_a_d;
  logic [ADDR_W-1:0] rf_adr_b_q, rf_adr_b_d;
  logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d;
  logic [DATA_W-1:0] rsp_data_b_q, rsp_data_b_d;

  logic              wq_full_s, wq_empty_s, wq_push_s, wq_pop_s;
  logic [ADDR_W-1:0] wq_head_addr_s;
  logic [DATA_W-1:0] wq_head_data_s;
  logic              hit_a_s, hit_b_s;
  logic [DATA_W-1:0] fwd_a_s, fwd_b_s;
  logic              wb_hs_s, rd_hs_s, rsp_hs_s;

  assign wb_ready  = !wq_full_s && (state_q != RD_WAIT);
  assign rd_ready  = (state_q == IDLE) && !wq_full_s;
  assign rsp_valid = (state_q == RESP);
  assign wb_hs_s   = wb_valid && wb_ready;
  assign rd_hs_s   = rd_valid && rd_ready;
  assign rsp_hs_s  = rsp_valid && rsp_ready;
  // Writes to r0 complete the handshake but never reach the queue.
  assign wq_push_s = wb_hs_s && (wb_addr != {ADDR_W{1'b0}});

  rf_wq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wq (
    .clk       (clk),
    .rst       (rst),
    .push      (wq_push_s),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (wq_pop_s),
    .full      (wq_full_s),
    .empty     (wq_empty_s),
    .head_addr (wq_head_addr_s),
    .head_data (wq_head_data_s),
    .lk_addr_a (rf_adr_a_q),
    .lk_addr_b (rf_adr_b_q),
    .lk_hit_a  (hit_a_s),
    .lk_hit_b  (hit_b_s),
    .lk_data_a (fwd_a_s),
    .lk_data_b (fwd_b_s)
  );

  // Next state, queue pop decision and register-file port values.
  always_comb begin
    state_d       = state_q;
    wq_pop_s      = 1'b0;
    rf_adr_a_d    = rf_adr_a_q;
    rf_adr_b_d    = rf_adr_b_q;
    rsp_data_a_d  = rsp_data_a_q;
    rsp_data_b_d  = rsp_data_b_q;
    case (state_q)
      IDLE: begin
        if (wq_full_s) begin
          wq_pop_s = 1'b1;
        end else if (rd_hs_s) begin
          rf_adr_a_d = rd_addr_a;
          rf_adr_b_d = rd_addr_b;
          state_d    = RD_WAIT;
        end else begin
          wq_pop_s = !wq_empty_s;
        end
      end
      RD_WAIT: begin
        if (rf_adr_a_q == {ADDR_W{1'b0}}) begin
          rsp_data_a_d = {DATA_W{1'b0}};
        end else if (hit_a_s) begin
          rsp_data_a_d = fwd_a_s;
        end else begin
          rsp_data_a_d = rf_data_a;
        end
        if (rf_adr_b_q == {ADDR_W{1'b0}}) begin
          rsp_data_b_d = {DATA_W{1'b0}};
        end else if (hit_b_s) begin
          rsp_data_b_d = fwd_b_s;
        end else begin
          rsp_data_b_d = rf_data_b;
        end
        state_d = RESP;
      end
      RESP: begin
        // The exit cycle leaves the queue alone; IDLE's full-drain rule picks up from there.
        if (rsp_hs_s) begin
          state_d = IDLE;
        end else begin
          wq_pop_s = !wq_empty_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rf_write_d    = wq_pop_s;
    rf_adr_save_d = wq_pop_s ? wq_head_addr_s : rf_adr_save_q;
    rf_data_out_d = wq_pop_s ? wq_head_data_s : rf_data_out_q;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rf_write_q    <= 1'b0;
      rf_adr_save_q <= {ADDR_W{1'b0}};
      rf_data_out_q <= {DATA_W{1'b0}};
      rf_adr_a_q    <= {ADDR_W{1'b0}};
      rf_adr_b_q    <= {ADDR_W{1'b0}};
      rsp_data_a_q  <= {DATA_W{1'b0}};
      rsp_data_b_q  <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      rf_write_q    <= rf_write_d;
      rf_adr_save_q <= rf_adr_save_d;
      rf_data_out_q <= rf_data_out_d;
      rf_adr_a_q    <= rf_adr_a_d;
      rf_adr_b_q    <= rf_adr_b_d;
      rsp_data_a_q  <= rsp_data_a_d;
      rsp_data_b_q  <= rsp_data_b_d;
    end
  end

  assign rf_write    = rf_write_q;
  assign rf_adr_save = rf_adr_save_q;
  assign rf_data_out = rf_data_out_q;
  assign rf_adr_a    = rf_adr_a_q;
  assign rf_adr_b    = rf_adr_b_q;
  assign rsp_data_a  = rsp_data_a_q;
  assign rsp_data_b  = rsp_data_b_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl: an architectural register model feeds a
// response scoreboard; a simple register-file model answers the read ports.
module tb_rf_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic          rf_write;
  logic [AW-1:0] rf_adr_save, rf_adr_a, rf_adr_b;
  logic [DW-1:0] rf_data_out, rf_data_a, rf_data_b;

  rf_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rf_write(rf_write), .rf_adr_save(rf_adr_save), .rf_data_out(rf_data_out),
    .rf_adr_a(rf_adr_a), .rf_adr_b(rf_adr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
  );

  always #5 clk = ~clk;

  // Register-file model: writes land at the edge, reads follow the address.
  logic          rf_clear = 1'b1;
  logic [DW-1:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (rf_write) begin
      rf_mem[rf_adr_save] <= rf_data_out;
    end
  end
  assign rf_data_a = rf_mem[rf_adr_a];
  assign rf_data_b = rf_mem[rf_adr_b];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] arch [16];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            wr_pulses = 0;
  int            p0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes before the edge, update model/scoreboard, advance.
  task automatic cycle();
    logic wb_hs, rd_hs, rsp_hs;
    exp_t e;
    wb_hs  = wb_valid && wb_ready;
    rd_hs  = rd_valid && rd_ready;
    rsp_hs = rsp_valid && rsp_ready;
    if (rf_write) wr_pulses++;
    if (!rst) begin
      if (wb_hs && (wb_addr != '0)) arch[wb_addr] = wb_data;
      if (rd_hs) begin
        e.a = arch[rd_addr_a];
        e.b = arch[rd_addr_b];
        sb.push_back(e);
      end
      if (rsp_hs) begin
        chk1("rsp_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_data_a", rsp_data_a, e.a);
          chk("rsp_data_b", rsp_data_b, e.b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Right after read acceptance: one RD_WAIT cycle, then RESP.
  task automatic post_rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    chk1("rdwait_rsp_valid", rsp_valid, 1'b0);
    chk1("rdwait_rd_ready", rd_ready, 1'b0);
    chk1("rdwait_wb_ready", wb_ready, 1'b0);
    chk1("rdwait_rf_write", rf_write, 1'b0);
    chk("rdwait_adr_a", DW'(rf_adr_a), DW'(a));
    chk("rdwait_adr_b", DW'(rf_adr_b), DW'(b));
    cycle();
    chk1("resp_rsp_valid", rsp_valid, 1'b1);
  endtask

  task automatic send_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = wb_ready;
      cycle();
    end
    wb_valid = 1'b0;
    chk1("wb_accepted", ok, 1'b1);
  endtask

  task automatic send_rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic ok;
    ok = 1'b0;
    rd_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = rd_ready;
      cycle();
    end
    rd_valid = 1'b0;
    chk1("rd_accepted", ok, 1'b1);
    post_rd(a, b);
  endtask

  task automatic send_both(input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    wb_valid = 1'b1; wb_addr = wa; wb_data = wd;
    rd_valid = 1'b1; rd_addr_a = ra; rd_addr_b = rb;
    chk1("both_ready", wb_ready && rd_ready, 1'b1);
    cycle();
    wb_valid = 1'b0;
    rd_valid = 1'b0;
    post_rd(ra, rb);
  endtask

  task automatic wait_rsp();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = rsp_valid && rsp_ready;
      cycle();
    end
    chk1("rsp_seen", ok, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) arch[i] = '0;
    idle(3);
    rf_clear = 1'b0;

    // Reset values
    chk1("rst_rf_write", rf_write, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_adr_save", DW'(rf_adr_save), '0);
    chk("rst_data_out", rf_data_out, '0);
    chk("rst_adr_a", DW'(rf_adr_a), '0);
    chk("rst_adr_b", DW'(rf_adr_b), '0);
    chk("rst_rsp_a", rsp_data_a, '0);
    chk("rst_rsp_b", rsp_data_b, '0);
    rst = 1'b0;
    cycle();
    chk1("rst_wb_ready", wb_ready, 1'b1);
    chk1("rst_rd_ready", rd_ready, 1'b1);

    // Two writes drain before the read; read returns both
    p0 = wr_pulses;
    send_wb(4'd5, 32'd555);
    send_wb(4'd3, 32'd333);
    idle(4);
    chk_int("two_wr_pulses", wr_pulses - p0, 2);
    chk("rf_r5", rf_mem[5], 32'd555);
    chk("rf_r3", rf_mem[3], 32'd333);
    send_rd(4'd5, 4'd3);
    wait_rsp();

    // Same-cycle write and read: forwarded while the RF still holds 0
    chk("rf_r7_before", rf_mem[7], 32'h0);
    send_both(4'd7, 32'h77, 4'd7, 4'd0);
    wait_rsp();
    idle(3);

    // Queue full in IDLE: read held off one cycle while one write drains
    send_wb(4'd4, 32'h11);
    send_both(4'd4, 32'h22, 4'd4, 4'd4);
    wait_rsp();
    p0 = wr_pulses;
    rd_valid = 1'b1; rd_addr_a = 4'd4; rd_addr_b = 4'd9;
    chk1("full_rd_ready", rd_ready, 1'b0);
    chk1("full_wb_ready", wb_ready, 1'b0);
    cycle();
    chk1("full_rf_write", rf_write, 1'b1);
    chk("full_adr_save", DW'(rf_adr_save), 32'd4);
    chk("full_data_out", rf_data_out, 32'h11);
    send_rd(4'd4, 4'd9);
    chk_int("full_one_pulse", wr_pulses - p0, 1);
    wait_rsp();
    idle(3);

    // Back-pressured response stays stable while a write to r9 drains
    rsp_ready = 1'b0;
    send_both(4'd9, 32'h99, 4'd9, 4'd5);
    p0 = wr_pulses;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_a", rsp_data_a, 32'h99);
      chk("hold_rsp_b", rsp_data_b, 32'd555);
    end
    chk_int("hold_drain_pulse", wr_pulses - p0, 1);
    chk("hold_rf_r9", rf_mem[9], 32'h99);
    rsp_ready = 1'b1;
    wait_rsp();
    idle(2);

    // Writes to r0 are dropped; r0 reads as zero
    p0 = wr_pulses;
    send_wb(4'd0, 32'd123);
    idle(4);
    chk_int("r0_no_pulse", wr_pulses - p0, 0);
    send_rd(4'd0, 4'd7);
    wait_rsp();
    idle(2);

    // Reset in RESP with a queued write: everything discarded
    rsp_ready = 1'b0;
    send_both(4'd11, 32'h1b, 4'd11, 4'd3);
    rst = 1'b1;
    arch[11] = 32'h0;
    sb.delete();
    p0 = wr_pulses;
    cycle();
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("mid_rst_rf_write", rf_write, 1'b0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk1("post_rst_wb_ready", wb_ready, 1'b1);
    chk1("post_rst_rd_ready", rd_ready, 1'b1);
    idle(4);
    chk_int("post_rst_no_write", wr_pulses - p0, 0);
    chk("post_rst_rf_r11", rf_mem[11], 32'h0);
    send_rd(4'd11, 4'd3);
    wait_rsp();
    idle(2);
    chk_int("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
